// File: rtl/dec_case.sv
// dec_case: 3-to-8 one-hot decoder written as a full case statement.
//   D   - combinational decode of X, independent of clk and rst_n.
//   D_Q - D registered on the rising edge of clk.
//   CHG - one-cycle pulse when the registered select code changes.
// Optional feature, macro DEC_HIST_EN: adds output HIT, a sticky OR of
// every decode captured since reset.
module dec_case #(
  parameter int N_SEL = 3,
  parameter int N_OUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SEL-1:0] X,
  output logic [N_OUT-1:0] D,
`ifdef DEC_HIST_EN
  output logic [N_OUT-1:0] HIT,
`endif
  output logic [N_OUT-1:0] D_Q,
  output logic             CHG
);

  // The case table below is written for exactly 3 select bits and 8 outputs.
  generate
    if (N_SEL != 3) begin : g_bad_sel
      $error("dec_case: N_SEL must be 3");
    end
    if (N_OUT != (1 << N_SEL)) begin : g_bad_out
      $error("dec_case: N_OUT must equal 2**N_SEL");
    end
  endgenerate

  logic [N_SEL-1:0] x_prev;
  logic             init;

  // Decode X to one-hot; unknown select bits fall through to all-zero.
  always_comb begin
    // NOTE: the default branch assigns D on every path, so no latch is inferred.
    unique case (X)
      3'b000:  D = 8'b0000_0001;
      3'b001:  D = 8'b0000_0010;
      3'b010:  D = 8'b0000_0100;
      3'b011:  D = 8'b0000_1000;
      3'b100:  D = 8'b0001_0000;
      3'b101:  D = 8'b0010_0000;
      3'b110:  D = 8'b0100_0000;
      3'b111:  D = 8'b1000_0000;
      default: D = 8'b0000_0000;
    endcase
  end

  // Register the decode and track the previous code to produce the change strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D_Q    <= '0;
      CHG    <= 1'b0;
      x_prev <= '0;
      init   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let CHG compare against the old x_prev
      // and the old init, so the first edge after reset never pulses.
      D_Q    <= D;
      x_prev <= X;
      CHG    <= (X != x_prev) && init;
      init   <= 1'b1;
    end
  end

`ifdef DEC_HIST_EN
  // Sticky record of every code decoded since reset; saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HIT <= '0;
    end else begin
      HIT <= HIT | D;
    end
  end
`endif

endmodule

// File: tb/tb_dec_case.sv
// Directed self-checking bench for dec_case. Build with +define+DEC_HIST_EN
// to also exercise the HIT history output.
module tb_dec_case;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [2:0] X;
  logic [7:0] D;
  logic [7:0] D_Q;
  logic       CHG;
`ifdef DEC_HIST_EN
  logic [7:0] HIT;
`endif

  int vec_cnt;
  int err_cnt;

  dec_case dut (
    .clk   (clk),
    .rst_n (rst_n),
    .X     (X),
    .D     (D),
`ifdef DEC_HIST_EN
    .HIT   (HIT),
`endif
    .D_Q   (D_Q),
    .CHG   (CHG)
  );

  // Gated clock so the combinational sweep can run with no edges at all.
  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_d [8];
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h04; exp_d[3] = 8'h08;
    exp_d[4] = 8'h10; exp_d[5] = 8'h20; exp_d[6] = 8'h40; exp_d[7] = 8'h80;

    vec_cnt = 0;
    err_cnt = 0;
    clk_en  = 1'b0;
    rst_n   = 1'b0;
    X       = 3'd0;
    #1;

    // Reset state with no clock running.
    check("rst_dq", D_Q, 8'h00);
    check("rst_chg", {7'b0, CHG}, 8'h00);
`ifdef DEC_HIST_EN
    check("rst_hit", HIT, 8'h00);
`endif

    // Combinational sweep, no clock.
    for (int i = 0; i < 8; i++) begin
      X = i[2:0];
      #20;
      check($sformatf("sweep_d%0d", i), D, exp_d[i]);
    end

    // Clock toggling while reset is held.
    X = 3'b101;
    clk_en = 1'b1;
    tick();
    tick();
    check("rsthold_d", D, 8'h20);
    check("rsthold_dq", D_Q, 8'h00);
    check("rsthold_chg", {7'b0, CHG}, 8'h00);

    // Release reset with X=3 held for three edges.
    X = 3'd3;
    rst_n = 1'b1;
    tick();
    check("rel_dq1", D_Q, 8'h08);
    check("rel_chg1", {7'b0, CHG}, 8'h00);
    tick();
    check("hold_chg2", {7'b0, CHG}, 8'h00);
    tick();
    check("hold_dq3", D_Q, 8'h08);
    check("hold_chg3", {7'b0, CHG}, 8'h00);

    // 6 -> 7 -> 0, including the wrap.
    X = 3'd6;
    tick();
    check("seq6_dq", D_Q, 8'h40);
    check("seq6_chg", {7'b0, CHG}, 8'h01);
    X = 3'd7;
    tick();
    check("seq7_dq", D_Q, 8'h80);
    check("seq7_chg", {7'b0, CHG}, 8'h01);
    X = 3'd0;
    tick();
    check("wrap_dq", D_Q, 8'h01);
    check("wrap_chg", {7'b0, CHG}, 8'h01);

    // Hold: strobe drops.
    tick();
    check("hold0_chg", {7'b0, CHG}, 8'h00);
    check("hold0_dq", D_Q, 8'h01);

    // Toggle every cycle: strobe stays high.
    for (int i = 0; i < 4; i++) begin
      X = (i % 2 == 0) ? 3'd1 : 3'd2;
      tick();
      check($sformatf("tog_chg%0d", i), {7'b0, CHG}, 8'h01);
      check($sformatf("tog_dq%0d", i), D_Q, (i % 2 == 0) ? 8'h02 : 8'h04);
    end

`ifdef DEC_HIST_EN
    // Codes seen so far since release: 3,6,7,0,1,2.
    check("hit_mid", HIT, 8'hCF);
`endif

    // Asynchronous reset mid-cycle.
    X = 3'd2;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_dq", D_Q, 8'h00);
    check("async_chg", {7'b0, CHG}, 8'h00);
    check("async_d", D, 8'h04);
`ifdef DEC_HIST_EN
    check("async_hit", HIT, 8'h00);
`endif
    tick();
    check("async_dq_held", D_Q, 8'h00);

    // Release and apply 0, 3, 7.
    X = 3'd0;
    rst_n = 1'b1;
    tick();
    check("r2_chg0", {7'b0, CHG}, 8'h00);
    check("r2_dq0", D_Q, 8'h01);
    X = 3'd3;
    tick();
    check("r2_chg3", {7'b0, CHG}, 8'h01);
    X = 3'd7;
    tick();
    check("r2_dq7", D_Q, 8'h80);
`ifdef DEC_HIST_EN
    check("hit_089", HIT, 8'h89);
    for (int i = 0; i < 8; i++) begin
      X = i[2:0];
      tick();
    end
    check("hit_ff", HIT, 8'hFF);
    X = 3'd4;
    tick();
    tick();
    check("hit_ff_hold", HIT, 8'hFF);
    rst_n = 1'b0;
    #1;
    check("hit_rst", HIT, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
